// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC, jump flag and boot/run/pause/step/halt sequencing
// in front of the instruction decoder.
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC   = 16'h0001,
   parameter logic [15:0] HOLD_INSTR = 16'hF800
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        step,
   input  logic        cnt_en,
   input  logic        pc_sload,
   input  logic [15:0] new_pc,
   input  logic [15:0] instr_q1,
   input  logic [15:0] instr_q2,
   input  logic        flag_wen,
   input  logic        alu_cond,
   output logic [15:0] pc,
   output logic [15:0] instr,
   output logic [15:0] N,
   output logic        jump,
   output logic        halted,
   output logic        exec
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_RUN,
      S_PAUSE,
      S_STEP,
      S_HALT
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [15:0] pc_nx;
   logic        jump_nx;
   logic [4:0]  op;
   logic        is_stp;
   logic        is_use;

   assign op = instr_q1[15:11];
   assign N  = instr_q2;

   // Opcode classes: STP halts, CMP/conditional SUB consume the flag.
   always_comb begin
      is_stp = (op == 5'b11111);
      is_use = (op == 5'b00010) || (op == 5'b00011) ||
               (op == 5'b01010) || (op == 5'b01011);
   end

   // Decoder-facing outputs come from the state register only.
   always_comb begin
      exec   = (state == S_RUN) || (state == S_STEP);
      halted = (state == S_HALT);
      instr  = exec ? instr_q1 : HOLD_INSTR;
   end

   // Next-state logic; HALT beats a falling run in RUN.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_BOOT:  state_nx = run ? S_RUN : S_PAUSE;
         S_RUN: begin
            if (is_stp)
               state_nx = S_HALT;
            else if (!run)
               state_nx = S_PAUSE;
         end
         S_PAUSE: begin
            if (run)
               state_nx = S_RUN;
            else if (step)
               state_nx = S_STEP;
         end
         S_STEP:  state_nx = is_stp ? S_HALT : S_PAUSE;
         S_HALT:  state_nx = S_HALT;
         default: state_nx = S_BOOT;
      endcase
   end

   // PC and flag only move while a real instruction executes.
   always_comb begin
      pc_nx   = pc;
      jump_nx = jump;
      if (exec) begin
         if (pc_sload)
            pc_nx = new_pc;
         else if (cnt_en)
            pc_nx = pc + 16'd1;
         if (flag_wen)
            jump_nx = alu_cond;
         else if (is_use)
            jump_nx = 1'b0;
      end
   end

   // State, PC and flag share one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_BOOT;
         pc    <= RESET_PC;
         jump  <= 1'b0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         jump  <= jump_nx;
      end
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch-sequencing stage directly upstream of the instruction decoder. It owns the 16-bit PC and the compare/jump flag. It presents the decoder with the current instruction word, the immediate word N and the jump condition. It also runs a small state machine (boot, run, pause, single-step, halt), forcing a hold instruction into the decoder whenever the core must not advance.

## Interface
- `RESET_PC`, default `16'h0001`: PC value after reset. Word 0 is fetched during BOOT.
- `HOLD_INSTR`, default `16'hF800`: STP encoding injected whenever execution is suppressed.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `run`, input, 1: level; 1 = free-run, 0 = pause.
- `step`, input, 1: single-cycle pulse; executes one instruction while paused.
- `cnt_en`, input, 1: from decoder; PC increments by 1.
- `pc_sload`, input, 1: from decoder; PC loads `new_pc`.
- `new_pc`, input, 16: from decoder; load value.
- `instr_q1`, input, 16: instruction memory port 1 read data (synchronous read, 1-cycle latency).
- `instr_q2`, input, 16: instruction memory port 2 read data.
- `flag_wen`, input, 1: ALU compare result valid this cycle.
- `alu_cond`, input, 1: ALU compare result.
- `pc`, output, 16: current PC, registered.
- `instr`, output, 16: instruction word to the decoder.
- `N`, output, 16: immediate word to the decoder; always `instr_q2`.
- `jump`, output, 1: registered jump flag to the decoder.
- `halted`, output, 1: 1 in HALT state.
- `exec`, output, 1: 1 when `instr` carries a real instruction (RUN or STEP).

## Operation
- Invariant: in every cycle, `instr_q1` = mem[pc-1] and `instr_q2` = mem[pc].
- The decoder drives the memory addresses. With the held PC, HOLD_INSTR addresses pc-1 and pc, so the invariant survives any number of hold cycles.
- **States.** BOOT (reset state), RUN, PAUSE, STEP, HALT.
  - BOOT → RUN if `run`, else PAUSE. This is unconditional after one cycle.
  - RUN → HALT if `instr_q1[15:11]==5'b11111`.
  - RUN → PAUSE if `run==0`. If both conditions hold, HALT wins.
  - PAUSE → RUN if `run`. PAUSE → STEP if `step` and `!run`.
  - STEP → HALT if `instr_q1[15:11]==5'b11111`, else → PAUSE.
  - HALT is left only by reset.
- **Instruction mux.** `instr` = `instr_q1` in RUN and STEP. In BOOT, PAUSE and HALT it is HOLD_INSTR.
- `exec` = 1 exactly in RUN and STEP.
- **PC update.** The PC changes only when `exec`=1.
  - `pc_sload` loads `new_pc`. Otherwise `cnt_en` gives `pc+1`. Otherwise the PC holds.
  - `pc_sload` has priority over `cnt_en` when both are asserted.
  - Increment wraps 16'hFFFF → 16'h0000, with no flag.
- **Jump flag.** Captures `alu_cond` when `flag_wen` is asserted and `exec`=1; otherwise it holds.
  - Cleared to 0 when `exec`=1 and `instr_q1[15:11]` ∈ {00010, 00011, 01010, 01011}, i.e. the flag is consumed by a CMP or conditional SUB.
  - If capture and clear coincide, capture wins.
- A `step` pulse seen outside PAUSE is ignored; it is neither queued nor remembered.

## Timing
- **Reset values** (asynchronous, while `rst_n`=0):
  - `pc`=RESET_PC
  - state=BOOT
  - `jump`=0
  - `halted`=0
  - `exec`=0
  - `instr`=HOLD_INSTR
  - `N` follows `instr_q2`, i.e. it is combinational.
- `instr`, `exec`, `halted` are decoded from the state register only; there is no combinational path from `run` or `step`.
- PC, flag and state update on the same edge. A decoder decision made in cycle t is visible on `pc` in t+1.
- The first real instruction (word 0) reaches the decoder in the second cycle after reset release.
- `run` falling in RUN: the instruction present in that cycle still executes; hold starts the next cycle.
- A `step` produces exactly one `exec` cycle, starting the cycle after the pulse.
- Reset asserted mid-instruction: all state returns to reset values immediately; no partial PC update survives.

## Test plan
- **Reset/boot:** release `rst_n` with `run`=1 and mem[0]=16'h0000 (NOP).
  - Cycle 1: `instr`=16'hF800, `exec`=0, `pc`=1.
  - Cycle 2: `instr`=16'h0000, `exec`=1.
  - Cycle 3: `pc`=2.
- **Load priority:** in RUN assert `cnt_en`=1, `pc_sload`=1, `new_pc`=16'h0040 → next `pc`=16'h0040.
- **Wrap:** `pc`=16'hFFFF, `cnt_en`=1 → `pc`=16'h0000.
- **Pause/step:**
  - Drop `run` at `pc`=5 → `pc` stays 5 and `instr`=16'hF800 for 10 cycles.
  - One `step` pulse with `cnt_en`=1 → exactly one `exec` cycle, then `pc`=6 and state PAUSE.
- **Halt:** `instr_q1`=16'hF800 in RUN → next cycle `halted`=1 and `exec`=0.
  - `run` and `step` toggling then has no effect; PC is frozen until `rst_n` pulses.
- **Jump flag:**
  - `flag_wen`=1 with `alu_cond`=1 → `jump`=1.
  - Next `exec` cycle with `instr_q1`=16'h1001 (CMP) → `jump`=0.
  - Repeat with `flag_wen` asserted in the CMP cycle → `jump` stays 1.
